t2mi_source_selector: RTL and testbench
=======================================

T2MI_SOURCE_SELECTOR -- requirements
Module: t2mi_source_selector

Interface
REQ-001 Parameter NUM_CH, default 4, number of input streams; legal range 2..8.
REQ-002 Parameter DATA_W, default 8, byte width of each stream.
REQ-003 Parameter TIMEOUT_CYC, default 1000000, idle cycles before a channel is declared dead.
REQ-004 Parameter HOLDOFF_CYC, default 1000, cycles a higher-priority channel must stay alive before the block pre-empts to it.
REQ-005 Parameter LED_DIV_BITS, default 24, width of the LED blink counter.
REQ-006 Localparam CW = max(1, clog2(NUM_CH)).
REQ-007 Port clk  in  1  single system clock; all logic on its rising edge.
REQ-008 Port rst_n  in  1  reset, asynchronous assert, active-low.
REQ-009 Port in_valid  in  NUM_CH  per-channel byte valid.
REQ-010 Port in_data  in  NUM_CH*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W].
REQ-011 Port in_start  in  NUM_CH  packet-start marker; counts only when the same channel's in_valid is high in that cycle.
REQ-012 Port ch_enable  in  NUM_CH  a low bit excludes that channel from selection.
REQ-013 Port force_en / force_ch  in  1 / CW  manual channel override.
REQ-014 Port out_valid / out_data / out_start  out  1 / DATA_W / 1  selected stream, registered.
REQ-015 Port active_ch  out  CW  index of the channel currently forwarded.
REQ-016 Port ch_alive  out  NUM_CH  per-channel liveness.
REQ-017 Port no_source  out  1  high in state IDLE.
REQ-018 Port switch_event  out  1  one-cycle pulse when active_ch changes.
REQ-019 Port led  out  1  status indicator.

Function
REQ-020 Watchdog: each channel has a saturating idle counter, cleared on its in_valid and incremented otherwise.
REQ-021 Liveness: ch_alive[i] = ch_enable[i] AND (idle counter < TIMEOUT_CYC).
REQ-022 Target: when force_en=1 and force_ch<NUM_CH, the target is force_ch regardless of liveness; otherwise it is the lowest-index live channel.
REQ-023 Out-of-range force_ch: treated as force_en=0.
REQ-024 States: IDLE, RUN and SWITCH_WAIT.
REQ-025 IDLE: the block forwards nothing. When any target exists, it latches it as candidate and enters SWITCH_WAIT.
REQ-026 RUN, target differs and current channel dead: latch candidate and enter SWITCH_WAIT immediately.
REQ-027 RUN, target differs and current channel alive: enter SWITCH_WAIT only after the target has been continuously alive and unchanged for HOLDOFF_CYC cycles. A forced target skips the holdoff.
REQ-028 SWITCH_WAIT: keep forwarding the old channel if it is alive (out_valid=0 otherwise) until a qualified in_start on the candidate.
REQ-029 SWITCH_WAIT, qualified in_start on candidate: in that same cycle active_ch becomes the candidate, the start byte itself is forwarded, switch_event pulses, and the state returns to RUN.
REQ-030 SWITCH_WAIT, candidate dies or target changes: re-evaluate. With a new target, latch it and remain in SWITCH_WAIT. With no target, return to RUN if the old channel is alive, else go to IDLE.
REQ-031 RUN, current channel dies with no other target: go to IDLE, out_valid=0.
REQ-032 Entry from IDLE: output starts only at a packet start, so no partial packet is ever emitted.
REQ-033 Latency: out_* are registered, exactly 1 cycle after the selected input.
REQ-034 Gating: out_valid = selected in_valid AND forwarding enabled. out_start is gated the same way.
REQ-035 LED: solid 1 when in RUN with active_ch=0.
REQ-036 LED: blink counter bit LED_DIV_BITS-1 when in RUN or SWITCH_WAIT on any other channel.
REQ-037 LED: blink counter bit LED_DIV_BITS-3 when in IDLE.
REQ-038 Blink counter: free-running and wraps modulo 2^LED_DIV_BITS.

Reset
REQ-039 While rst_n=0: state IDLE, all idle counters = TIMEOUT_CYC (all channels dead), holdoff counter 0, LED counter 0.
REQ-040 While rst_n=0: out_valid=0, out_data=0, out_start=0, active_ch=0, ch_alive=0, no_source=1, switch_event=0, led=0.
REQ-041 Reset asserted mid-packet or in SWITCH_WAIT: abort immediately, no further output bytes.

Verification (bench: NUM_CH=4, TIMEOUT_CYC=16, HOLDOFF_CYC=8, LED_DIV_BITS=6)
REQ-042 Scenario 1: after reset, ch2 sends bytes mid-packet, then in_start with data 0x47. Required: no output before the start; out_data=0x47 with out_start=1 one cycle later; active_ch=2; switch_event pulses once; no_source falls.
REQ-043 Scenario 2: ch2 running, ch0 becomes alive. Required: no switch within 8 cycles. Then a switch at ch0's next in_start; the last ch2 byte appears immediately before the ch0 start byte with no gap or duplicate.
REQ-044 Scenario 3: ch0 active, ch0 in_valid stops for 16 cycles with ch1 alive. Required: ch_alive[0] falls; at ch1's next in_start, active_ch=1 with no holdoff wait.
REQ-045 Scenario 4: force_en=1, force_ch=3 while ch3 is dead; then ch3 starts. Required: out_valid=0 until ch3's in_start, then active_ch=3. force_ch=5 while force_en=1 is ignored.
REQ-046 Scenario 5: all channels stop. Required: after 16 cycles no_source=1, out_valid=0, led toggles on counter bit 3. rst_n pulsed low mid-packet: all outputs at reset values in the same cycle.

Source files
------------

// File: rtl/t2mi_source_selector.sv
// t2mi_source_selector: picks one of NUM_CH byte streams by priority and liveness.
// A switch only takes effect on a packet start, so no partial packet is ever emitted.
module t2mi_source_selector #(
    parameter int NUM_CH       = 4,
    parameter int DATA_W       = 8,
    parameter int TIMEOUT_CYC  = 1000000,
    parameter int HOLDOFF_CYC  = 1000,
    parameter int LED_DIV_BITS = 24,
    localparam int CW = ($clog2(NUM_CH) > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH-1:0]        in_valid,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    input  logic [NUM_CH-1:0]        in_start,
    input  logic [NUM_CH-1:0]        ch_enable,
    input  logic                     force_en,
    input  logic [CW-1:0]            force_ch,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_start,
    output logic [CW-1:0]            active_ch,
    output logic [NUM_CH-1:0]        ch_alive,
    output logic                     no_source,
    output logic                     switch_event,
    output logic                     led
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam int HW = (HOLDOFF_CYC > 0) ? $clog2(HOLDOFF_CYC + 1) : 1;
    localparam logic [TW-1:0] TIMEOUT_V = TW'(TIMEOUT_CYC);
    localparam logic [HW-1:0] HOLD_V    = HW'(HOLDOFF_CYC);

    typedef enum logic [1:0] {
        S_IDLE        = 2'd0,
        S_RUN         = 2'd1,
        S_SWITCH_WAIT = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_nextState;
    logic [TW-1:0]           r_idleCnt [NUM_CH];
    logic [NUM_CH-1:0]       w_alive;
    logic                    w_forceOk;
    logic                    w_hasTarget;
    logic [CW-1:0]           w_target;
    logic [CW-1:0]           r_active;
    logic [CW-1:0]           r_cand;
    logic [CW-1:0]           w_candNext;
    logic                    r_fwdOld;
    logic                    w_fwdOldNext;
    logic                    w_doSwitch;
    logic                    w_curAlive;
    logic                    w_candStart;
    logic [HW-1:0]           r_hold;
    logic [HW-1:0]           w_holdNow;
    logic [CW-1:0]           r_holdTgt;
    logic                    w_holdArm;
    logic                    w_holdDone;
    logic [CW-1:0]           w_sel;
    logic                    w_fwdEn;
    logic                    w_selValid;
    logic                    w_selStart;
    logic [DATA_W-1:0]       w_selData;
    logic [LED_DIV_BITS-1:0] r_ledCnt;
    logic                    r_outValid;
    logic                    r_outStart;
    logic [DATA_W-1:0]       r_outData;
    logic                    r_switchEvent;

    // Per-channel watchdog: cleared by traffic, saturates at the timeout (reset means dead).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) r_idleCnt[i] <= TIMEOUT_V;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (in_valid[i])                    r_idleCnt[i] <= '0;
                else if (r_idleCnt[i] != TIMEOUT_V) r_idleCnt[i] <= r_idleCnt[i] + 1'b1;
            end
        end
    end

    // Liveness and target choice: an in-range force wins, otherwise the lowest live channel.
    always_comb begin
        w_alive     = '0;
        w_hasTarget = 1'b0;
        w_target    = '0;
        w_forceOk   = force_en && ({1'b0, force_ch} < (CW+1)'(NUM_CH));
        for (int i = 0; i < NUM_CH; i++) w_alive[i] = ch_enable[i] && (r_idleCnt[i] < TIMEOUT_V);
        if (w_forceOk) begin
            w_target    = force_ch;
            w_hasTarget = 1'b1;
        end else begin
            for (int i = NUM_CH - 1; i >= 0; i--) begin
                if (w_alive[i]) begin
                    w_target    = CW'(i);
                    w_hasTarget = 1'b1;
                end
            end
        end
    end

    assign w_curAlive  = w_alive[r_active];
    assign w_candStart = in_valid[r_cand] && in_start[r_cand];

    // Holdoff: a better channel must stay the same live target for HOLDOFF_CYC cycles in a row.
    always_comb begin
        w_holdArm = (r_state == S_RUN) && w_hasTarget && (w_target != r_active) &&
                    w_curAlive && !w_forceOk;
        if ((r_hold != '0) && (w_target == r_holdTgt))
            w_holdNow = (r_hold == HOLD_V) ? HOLD_V : r_hold + 1'b1;
        else
            w_holdNow = HW'(1);
        w_holdDone = w_holdArm && (w_holdNow >= HOLD_V);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_nextState;
    end

    // Next-state logic: decide when to arm a switch and when the candidate's packet start lands.
    always_comb begin
        w_nextState  = r_state;
        w_candNext   = r_cand;
        w_fwdOldNext = r_fwdOld;
        w_doSwitch   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_hasTarget) begin
                    w_nextState  = S_SWITCH_WAIT;
                    w_candNext   = w_target;
                    w_fwdOldNext = 1'b0;
                end
            end
            S_RUN: begin
                if (!w_hasTarget) begin
                    if (!w_curAlive) w_nextState = S_IDLE;
                end else if (w_target != r_active) begin
                    if (!w_curAlive || w_forceOk || w_holdDone) begin
                        w_nextState  = S_SWITCH_WAIT;
                        w_candNext   = w_target;
                        w_fwdOldNext = 1'b1;
                    end
                end
            end
            S_SWITCH_WAIT: begin
                if (w_hasTarget && (w_target == r_cand)) begin
                    if (w_candStart) begin
                        w_doSwitch  = 1'b1;
                        w_nextState = S_RUN;
                    end
                end else if (w_hasTarget && r_fwdOld && w_curAlive && (w_target == r_active)) begin
                    w_nextState = S_RUN;
                end else if (w_hasTarget) begin
                    w_candNext = w_target;
                end else if (r_fwdOld && w_curAlive) begin
                    w_nextState = S_RUN;
                end else begin
                    w_nextState = S_IDLE;
                end
            end
            default: w_nextState = S_IDLE;
        endcase
    end

    // Output decode: which channel feeds the output register, and the LED pattern.
    always_comb begin
        w_sel   = r_active;
        w_fwdEn = 1'b0;
        led     = r_ledCnt[LED_DIV_BITS-1];
        case (r_state)
            S_RUN: begin
                w_fwdEn = 1'b1;
                if (r_active == '0) led = 1'b1;
            end
            S_SWITCH_WAIT: begin
                if (w_doSwitch) begin
                    w_sel   = r_cand;
                    w_fwdEn = 1'b1;
                end else begin
                    w_fwdEn = r_fwdOld && w_curAlive;
                end
            end
            default: led = r_ledCnt[LED_DIV_BITS-3];
        endcase
    end

    // Input mux for the selected channel.
    always_comb begin
        w_selValid = 1'b0;
        w_selStart = 1'b0;
        w_selData  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_sel == CW'(i)) begin
                w_selValid = in_valid[i];
                w_selStart = in_start[i] && in_valid[i];
                w_selData  = in_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Datapath registers: active/candidate tracking, holdoff counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active      <= '0;
            r_cand        <= '0;
            r_fwdOld      <= 1'b0;
            r_hold        <= '0;
            r_holdTgt     <= '0;
            r_outValid    <= 1'b0;
            r_outStart    <= 1'b0;
            r_outData     <= '0;
            r_switchEvent <= 1'b0;
        end else begin
            r_cand        <= w_candNext;
            r_fwdOld      <= w_fwdOldNext;
            r_hold        <= w_holdArm ? w_holdNow : '0;
            r_holdTgt     <= w_target;
            r_switchEvent <= w_doSwitch && (r_cand != r_active);
            if (w_doSwitch) r_active <= r_cand;
            r_outValid    <= w_selValid && w_fwdEn;
            r_outStart    <= w_selStart && w_fwdEn;
            if (w_selValid && w_fwdEn) r_outData <= w_selData;
        end
    end

    // Free-running blink counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_ledCnt <= '0;
        else        r_ledCnt <= r_ledCnt + 1'b1;
    end

    assign out_valid    = r_outValid;
    assign out_start    = r_outStart;
    assign out_data     = r_outData;
    assign active_ch    = r_active;
    assign ch_alive     = w_alive;
    assign no_source    = (r_state == S_IDLE);
    assign switch_event = r_switchEvent;

endmodule

// File: tb/tb_t2mi_source_selector.sv
// Directed bench for t2mi_source_selector: startup, holdoff pre-emption, failover,
// forced selection, idle/LED behaviour, out-of-range force and mid-packet reset.
module tb_t2mi_source_selector;

    localparam int NUM_CH       = 4;
    localparam int DATA_W       = 8;
    localparam int TIMEOUT_CYC  = 16;
    localparam int HOLDOFF_CYC  = 8;
    localparam int LED_DIV_BITS = 6;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  in_valid  = '0;
    logic [3:0]  in_start  = '0;
    logic [31:0] in_data   = '0;
    logic [3:0]  ch_enable = 4'hF;
    logic        force_en  = 1'b0;
    logic [1:0]  force_ch  = '0;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_start;
    logic [1:0]  active_ch;
    logic [3:0]  ch_alive;
    logic        no_source;
    logic        switch_event;
    logic        led;

    // Second instance with five channels so an out-of-range force index is expressible.
    logic [4:0]  v2Valid = '0;
    logic [4:0]  v2Start = '0;
    logic [39:0] v2Data  = '0;
    logic        force2En = 1'b0;
    logic [2:0]  force2Ch = '0;
    logic        out2Valid;
    logic [7:0]  out2Data;
    logic        out2Start;
    logic [2:0]  active2Ch;
    logic [4:0]  alive2;
    logic        noSource2;
    logic        switch2;
    logic        led2;

    int          nAssert = 0;
    int          nFail   = 0;
    logic [5:0]  tbLedCnt;

    t2mi_source_selector #(
        .NUM_CH(NUM_CH), .DATA_W(DATA_W), .TIMEOUT_CYC(TIMEOUT_CYC),
        .HOLDOFF_CYC(HOLDOFF_CYC), .LED_DIV_BITS(LED_DIV_BITS)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_start(in_start), .ch_enable(ch_enable), .force_en(force_en),
        .force_ch(force_ch), .out_valid(out_valid), .out_data(out_data),
        .out_start(out_start), .active_ch(active_ch), .ch_alive(ch_alive),
        .no_source(no_source), .switch_event(switch_event), .led(led)
    );

    t2mi_source_selector #(
        .NUM_CH(5), .DATA_W(DATA_W), .TIMEOUT_CYC(TIMEOUT_CYC),
        .HOLDOFF_CYC(HOLDOFF_CYC), .LED_DIV_BITS(LED_DIV_BITS)
    ) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(v2Valid), .in_data(v2Data),
        .in_start(v2Start), .ch_enable(5'h1F), .force_en(force2En),
        .force_ch(force2Ch), .out_valid(out2Valid), .out_data(out2Data),
        .out_start(out2Start), .active_ch(active2Ch), .ch_alive(alive2),
        .no_source(noSource2), .switch_event(switch2), .led(led2)
    );

    always #5 clk = ~clk;

    // Reference blink counter: counts every clock since reset was released.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tbLedCnt <= '0;
        else        tbLedCnt <= tbLedCnt + 6'd1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int ch, input logic v, input logic s, input logic [7:0] d);
        in_valid[ch]      = v;
        in_start[ch]      = s;
        in_data[ch*8 +: 8] = d;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAssert++;
        assert (obs === exp) else begin
            nFail++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset state
        tick(); tick(); tick();
        checkOutput("rst_out_valid", 32'(out_valid), 0);
        checkOutput("rst_no_source", 32'(no_source), 1);
        checkOutput("rst_ch_alive", 32'(ch_alive), 0);
        checkOutput("rst_active", 32'(active_ch), 0);
        checkOutput("rst_led", 32'(led), 0);
        rst_n = 1'b1;

        // Scenario 1: ch2 joins mid-packet, output waits for its start byte
        $display("[TB] scenario 1: startup on ch2");
        for (int k = 0; k < 3; k++) begin
            applyStimulus(2, 1'b1, 1'b0, 8'(8'h10 + k));
            tick();
            checkOutput("s1_no_partial", 32'(out_valid), 0);
        end
        applyStimulus(2, 1'b1, 1'b1, 8'h47);
        tick();
        checkOutput("s1_valid", 32'(out_valid), 1);
        checkOutput("s1_data", 32'(out_data), 32'h47);
        checkOutput("s1_start", 32'(out_start), 1);
        checkOutput("s1_active", 32'(active_ch), 2);
        checkOutput("s1_event", 32'(switch_event), 1);
        checkOutput("s1_no_source", 32'(no_source), 0);
        applyStimulus(2, 1'b1, 1'b0, 8'h48);
        tick();
        checkOutput("s1_data2", 32'(out_data), 32'h48);
        checkOutput("s1_start2", 32'(out_start), 0);
        checkOutput("s1_event_once", 32'(switch_event), 0);
        checkOutput("s1_led_blink", 32'(led), 32'(tbLedCnt[5]));

        // Scenario 2: ch0 appears, holdoff keeps ch2 even through an early ch0 start
        $display("[TB] scenario 2: holdoff pre-emption to ch0");
        for (int k = 1; k <= 9; k++) begin
            applyStimulus(2, 1'b1, 1'b0, 8'(8'h20 + k));
            applyStimulus(0, 1'b1, (k == 5), 8'(8'hA0 + k));
            tick();
            checkOutput("s2_hold_active", 32'(active_ch), 2);
            checkOutput("s2_hold_data", 32'(out_data), 32'(8'h20 + k));
            checkOutput("s2_hold_event", 32'(switch_event), 0);
        end
        for (int k = 10; k <= 11; k++) begin
            applyStimulus(2, 1'b1, 1'b0, 8'(8'h20 + k));
            applyStimulus(0, 1'b1, 1'b0, 8'(8'hA0 + k));
            tick();
        end
        checkOutput("s2_last_old_valid", 32'(out_valid), 1);
        checkOutput("s2_last_old_data", 32'(out_data), 32'h2B);
        checkOutput("s2_last_old_active", 32'(active_ch), 2);
        applyStimulus(2, 1'b1, 1'b0, 8'h2C);
        applyStimulus(0, 1'b1, 1'b1, 8'hAC);
        tick();
        checkOutput("s2_sw_data", 32'(out_data), 32'hAC);
        checkOutput("s2_sw_start", 32'(out_start), 1);
        checkOutput("s2_sw_active", 32'(active_ch), 0);
        checkOutput("s2_sw_event", 32'(switch_event), 1);
        applyStimulus(2, 1'b0, 1'b0, 8'h00);
        applyStimulus(0, 1'b1, 1'b0, 8'hAD);
        tick();
        checkOutput("s2_next_data", 32'(out_data), 32'hAD);
        checkOutput("s2_led_solid", 32'(led), 1);

        // Scenario 3: ch0 goes silent, failover to ch1 without holdoff
        $display("[TB] scenario 3: failover to ch1");
        for (int k = 0; k < 2; k++) begin
            applyStimulus(0, 1'b1, 1'b0, 8'(8'hAE + k));
            applyStimulus(1, 1'b1, 1'b0, 8'h50);
            tick();
        end
        applyStimulus(0, 1'b0, 1'b0, 8'h00);
        for (int k = 0; k < 15; k++) tick();
        checkOutput("s3_alive_before_timeout", 32'(ch_alive[0]), 1);
        checkOutput("s3_active_before_timeout", 32'(active_ch), 0);
        tick();
        checkOutput("s3_dead_at_timeout", 32'(ch_alive[0]), 0);
        checkOutput("s3_ch1_alive", 32'(ch_alive[1]), 1);
        tick();
        checkOutput("s3_gap_valid", 32'(out_valid), 0);
        applyStimulus(1, 1'b1, 1'b1, 8'h5A);
        tick();
        checkOutput("s3_active", 32'(active_ch), 1);
        checkOutput("s3_data", 32'(out_data), 32'h5A);
        checkOutput("s3_start", 32'(out_start), 1);
        checkOutput("s3_event", 32'(switch_event), 1);

        // Scenario 4: all silent, then force onto a dead ch3
        $display("[TB] scenario 4: forced ch3");
        applyStimulus(1, 1'b0, 1'b0, 8'h00);
        for (int k = 0; k < 17; k++) tick();
        checkOutput("s4_idle_no_source", 32'(no_source), 1);
        checkOutput("s4_idle_valid", 32'(out_valid), 0);
        force_en = 1'b1;
        force_ch = 2'd3;
        tick();
        checkOutput("s4_wait_no_source", 32'(no_source), 0);
        for (int k = 0; k < 2; k++) begin
            applyStimulus(3, 1'b1, 1'b0, 8'(8'h30 + k));
            tick();
            checkOutput("s4_wait_valid", 32'(out_valid), 0);
        end
        applyStimulus(3, 1'b1, 1'b1, 8'h33);
        tick();
        checkOutput("s4_valid", 32'(out_valid), 1);
        checkOutput("s4_data", 32'(out_data), 32'h33);
        checkOutput("s4_active", 32'(active_ch), 3);
        checkOutput("s4_event", 32'(switch_event), 1);
        force_en = 1'b0;
        applyStimulus(3, 1'b1, 1'b0, 8'h34);
        tick();
        checkOutput("s4_stay_active", 32'(active_ch), 3);
        checkOutput("s4_stay_data", 32'(out_data), 32'h34);
        checkOutput("s4_stay_event", 32'(switch_event), 0);
        checkOutput("s4_led_blink", 32'(led), 32'(tbLedCnt[5]));

        // Scenario 5: everything stops, IDLE with fast LED blink
        $display("[TB] scenario 5: no source");
        applyStimulus(3, 1'b0, 1'b0, 8'h00);
        for (int k = 0; k < 17; k++) tick();
        checkOutput("s5_no_source", 32'(no_source), 1);
        checkOutput("s5_valid", 32'(out_valid), 0);
        checkOutput("s5_alive", 32'(ch_alive), 0);
        for (int k = 0; k < 16; k++) begin
            tick();
            checkOutput("s5_led_bit3", 32'(led), 32'(tbLedCnt[3]));
        end

        // Out-of-range force index on the five-channel instance is ignored
        $display("[TB] out-of-range force on five-channel instance");
        force2En = 1'b1;
        force2Ch = 3'd5;
        v2Valid[0] = 1'b1; v2Data[7:0] = 8'h90; tick();
        v2Data[7:0] = 8'h91; tick();
        checkOutput("oor_wait_valid", 32'(out2Valid), 0);
        v2Start[0] = 1'b1; v2Data[7:0] = 8'h99; tick();
        checkOutput("oor_valid", 32'(out2Valid), 1);
        checkOutput("oor_data", 32'(out2Data), 32'h99);
        checkOutput("oor_active", 32'(active2Ch), 0);
        checkOutput("oor_no_source", 32'(noSource2), 0);
        v2Valid[0] = 1'b0; v2Start[0] = 1'b0;

        // Reset pulse in the middle of a ch2 packet
        $display("[TB] reset mid-packet");
        applyStimulus(2, 1'b1, 1'b0, 8'h60); tick();
        applyStimulus(2, 1'b1, 1'b0, 8'h61); tick();
        applyStimulus(2, 1'b1, 1'b1, 8'h62); tick();
        checkOutput("r_pre_valid", 32'(out_valid), 1);
        checkOutput("r_pre_data", 32'(out_data), 32'h62);
        applyStimulus(2, 1'b1, 1'b0, 8'h63); tick();
        checkOutput("r_pre_data2", 32'(out_data), 32'h63);
        applyStimulus(2, 1'b1, 1'b0, 8'h64);
        rst_n = 1'b0;
        #1;
        checkOutput("r_out_valid", 32'(out_valid), 0);
        checkOutput("r_out_data", 32'(out_data), 0);
        checkOutput("r_out_start", 32'(out_start), 0);
        checkOutput("r_active", 32'(active_ch), 0);
        checkOutput("r_ch_alive", 32'(ch_alive), 0);
        checkOutput("r_no_source", 32'(no_source), 1);
        checkOutput("r_switch_event", 32'(switch_event), 0);
        checkOutput("r_led", 32'(led), 0);
        tick(); tick();
        checkOutput("r_held_valid", 32'(out_valid), 0);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            applyStimulus(2, 1'b1, 1'b0, 8'(8'h65 + k));
            tick();
            checkOutput("r_after_valid", 32'(out_valid), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule
